// File: rtl/sram16_ctl_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram16_ctl_pkg;

    // Width of the wait-state counter (WAIT_CYCLES range 0..15)
    localparam int unsigned CNT_W = 4;

    // s_siz_i encodings
    localparam logic SIZ_BYTE  = 1'b0;
    localparam logic SIZ_HWORD = 1'b1;

    // Controller states; ST_TURN is only reachable with the turnaround option
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    // Request fields latched when a transaction is accepted
    typedef struct packed {
        logic we;
        logic siz;
        logic lane;
    } req_t;

endpackage

// File: rtl/sram16_lanes.sv
// Byte-lane steering: write replication, read right-justification, UB/LB decode.
module sram16_lanes
    import sram16_ctl_pkg::*;
(
    input  logic        siz,
    input  logic        lane,
    input  logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic [15:0] wr_dat_c,
    output logic [15:0] rd_dat_c,
    output logic        ub_n_c,
    output logic        lb_n_c
);

    // Steer data and decode lane strobes; a halfword ignores the lane bit
    always_comb begin
        wr_dat_c = wdata;
        rd_dat_c = rdata;
        ub_n_c   = 1'b0;
        lb_n_c   = 1'b0;
        if (siz == SIZ_BYTE) begin
            wr_dat_c = {wdata[7:0], wdata[7:0]};
            if (lane) begin
                rd_dat_c = {8'h00, rdata[15:8]};
                lb_n_c   = 1'b1;
            end else begin
                rd_dat_c = {8'h00, rdata[7:0]};
                ub_n_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram16_ctl.sv
// 16-bit bus slave driving an asynchronous 16-bit SRAM with UB/LB strobes.
// Optional feature: define SRAM16_CTL_TURNAROUND_EN to insert one idle-bus
// TURN cycle before a write that directly follows a completed read.
module sram16_ctl
    import sram16_ctl_pkg::*;
#(
    parameter int unsigned ADR_W       = 19,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [63:0]      s_adr_i,
    input  logic             s_cyc_i,
    input  logic             s_stb_i,
    input  logic             s_we_i,
    input  logic             s_siz_i,
    input  logic             s_signed_i,
    input  logic [15:0]      s_dat_i,
    output logic             s_ack_o,
    output logic [15:0]      s_dat_o,
    output logic [ADR_W-1:0] sram_adr_o,
    output logic [15:0]      sram_dat_o,
    output logic             sram_dat_oe_o,
    input  logic [15:0]      sram_dat_i,
    output logic             sram_ce_n_o,
    output logic             sram_oe_n_o,
    output logic             sram_we_n_o,
    output logic             sram_ub_n_o,
    output logic             sram_lb_n_o
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t           state;
    req_t             req;
    logic [CNT_W-1:0] cnt;
    logic             abort;
`ifdef SRAM16_CTL_TURNAROUND_EN
    logic             prev_rd;
`endif

    logic             sel_siz;
    logic             sel_lane;
    logic [15:0]      wr_dat_c;
    logic [15:0]      rd_dat_c;
    logic             ub_n_c;
    logic             lb_n_c;

    // Sign handling is done upstream and only the SRAM-sized address slice matters
    logic unused_ok;
    assign unused_ok = ^{s_signed_i, s_adr_i[63:ADR_W+1]};

    // Lane decode follows the incoming request in IDLE, the latched one otherwise
    always_comb begin
        sel_siz  = req.siz;
        sel_lane = req.lane;
        if (state == ST_IDLE) begin
            sel_siz  = s_siz_i;
            sel_lane = s_adr_i[0];
        end
    end

    sram16_lanes u_lanes (
        .siz      (sel_siz),
        .lane     (sel_lane),
        .wdata    (s_dat_i),
        .rdata    (sram_dat_i),
        .wr_dat_c (wr_dat_c),
        .rd_dat_c (rd_dat_c),
        .ub_n_c   (ub_n_c),
        .lb_n_c   (lb_n_c)
    );

    // Transaction FSM with wait-state counter; all bus and SRAM outputs registered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            req           <= '0;
            cnt           <= '0;
            abort         <= 1'b0;
            s_ack_o       <= 1'b0;
            s_dat_o       <= 16'h0000;
            sram_adr_o    <= '0;
            sram_dat_o    <= 16'h0000;
            sram_dat_oe_o <= 1'b0;
            sram_ce_n_o   <= 1'b1;
            sram_oe_n_o   <= 1'b1;
            sram_we_n_o   <= 1'b1;
            sram_ub_n_o   <= 1'b1;
            sram_lb_n_o   <= 1'b1;
`ifdef SRAM16_CTL_TURNAROUND_EN
            prev_rd       <= 1'b0;
`endif
        end else begin
            s_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sram_ce_n_o   <= 1'b1;
                    sram_oe_n_o   <= 1'b1;
                    sram_we_n_o   <= 1'b1;
                    sram_ub_n_o   <= 1'b1;
                    sram_lb_n_o   <= 1'b1;
                    sram_dat_oe_o <= 1'b0;
`ifdef SRAM16_CTL_TURNAROUND_EN
                    prev_rd       <= 1'b0;
`endif
                    if (s_cyc_i && s_stb_i) begin
                        req.we     <= s_we_i;
                        req.siz    <= s_siz_i;
                        req.lane   <= s_adr_i[0];
                        sram_adr_o <= s_adr_i[ADR_W:1];
                        sram_dat_o <= wr_dat_c;
                        cnt        <= WAIT_LOAD;
                        abort      <= 1'b0;
`ifdef SRAM16_CTL_TURNAROUND_EN
                        if (s_we_i && prev_rd) begin
                            state <= ST_TURN;
                        end else begin
                            state         <= ST_ACCESS;
                            sram_ce_n_o   <= 1'b0;
                            sram_oe_n_o   <= s_we_i;
                            sram_we_n_o   <= ~s_we_i;
                            sram_dat_oe_o <= s_we_i;
                            sram_ub_n_o   <= ub_n_c;
                            sram_lb_n_o   <= lb_n_c;
                        end
`else
                        state         <= ST_ACCESS;
                        sram_ce_n_o   <= 1'b0;
                        sram_oe_n_o   <= s_we_i;
                        sram_we_n_o   <= ~s_we_i;
                        sram_dat_oe_o <= s_we_i;
                        sram_ub_n_o   <= ub_n_c;
                        sram_lb_n_o   <= lb_n_c;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (!s_cyc_i) begin
                        abort <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state       <= ST_ACK;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        sram_ub_n_o <= 1'b1;
                        sram_lb_n_o <= 1'b1;
                        s_ack_o     <= s_cyc_i & ~abort;
                        if (!req.we) begin
                            s_dat_o <= rd_dat_c;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    state         <= ST_IDLE;
                    sram_ce_n_o   <= 1'b1;
                    sram_dat_oe_o <= 1'b0;
`ifdef SRAM16_CTL_TURNAROUND_EN
                    prev_rd       <= ~req.we;
`endif
                end
`ifdef SRAM16_CTL_TURNAROUND_EN
                ST_TURN: begin
                    if (!s_cyc_i) begin
                        abort <= 1'b1;
                    end
                    state         <= ST_ACCESS;
                    sram_ce_n_o   <= 1'b0;
                    sram_oe_n_o   <= req.we;
                    sram_we_n_o   <= ~req.we;
                    sram_dat_oe_o <= req.we;
                    sram_ub_n_o   <= ub_n_c;
                    sram_lb_n_o   <= lb_n_c;
                end
`endif
                default: begin
                    state         <= ST_IDLE;
                    sram_ce_n_o   <= 1'b1;
                    sram_oe_n_o   <= 1'b1;
                    sram_we_n_o   <= 1'b1;
                    sram_ub_n_o   <= 1'b1;
                    sram_lb_n_o   <= 1'b1;
                    sram_dat_oe_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram16_ctl.sv
// Directed self-checking bench for sram16_ctl (ADR_W=19, WAIT_CYCLES=2).
module tb_sram16_ctl;

    logic        clk;
    logic        reset_i;
    logic [63:0] s_adr;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic        s_siz;
    logic        s_signed;
    logic [15:0] s_dat;
    logic        s_ack_o;
    logic [15:0] s_dat_o;
    logic [18:0] sram_adr_o;
    logic [15:0] sram_dat_o;
    logic        sram_dat_oe_o;
    logic [15:0] sram_dat_i;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic        sram_ub_n_o;
    logic        sram_lb_n_o;

    logic [15:0] rd_def;
    int          n_tests;
    int          n_fail;

    sram16_ctl #(.ADR_W(19), .WAIT_CYCLES(2)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .s_adr_i       (s_adr),
        .s_cyc_i       (s_cyc),
        .s_stb_i       (s_stb),
        .s_we_i        (s_we),
        .s_siz_i       (s_siz),
        .s_signed_i    (s_signed),
        .s_dat_i       (s_dat),
        .s_ack_o       (s_ack_o),
        .s_dat_o       (s_dat_o),
        .sram_adr_o    (sram_adr_o),
        .sram_dat_o    (sram_dat_o),
        .sram_dat_oe_o (sram_dat_oe_o),
        .sram_dat_i    (sram_dat_i),
        .sram_ce_n_o   (sram_ce_n_o),
        .sram_oe_n_o   (sram_oe_n_o),
        .sram_we_n_o   (sram_we_n_o),
        .sram_ub_n_o   (sram_ub_n_o),
        .sram_lb_n_o   (sram_lb_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read data: two fixed words for the two-beat test, otherwise rd_def
    always_comb begin
        sram_dat_i = rd_def;
        if (sram_adr_o == 19'h0088B) sram_dat_i = 16'hDEAD;
        if (sram_adr_o == 19'h0088A) sram_dat_i = 16'hBEEF;
    end

    function automatic logic [4:0] ctl();
        return {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated transaction; exp_val is read data (read) or pad data (write)
    task automatic xfer(input string tag, input logic [63:0] adr, input logic we,
                        input logic siz, input logic [15:0] wd,
                        input logic [4:0] exp_ctl, input logic [15:0] exp_val);
        s_adr = adr;
        s_we  = we;
        s_siz = siz;
        s_dat = wd;
        s_cyc = 1'b1;
        s_stb = 1'b1;
        tick();
        s_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_ctl"}, ctl(), exp_ctl);
            check({tag, "_doe"}, sram_dat_oe_o, we);
            check({tag, "_ack0"}, s_ack_o, 1'b0);
            if (i == 0) check({tag, "_adr"}, sram_adr_o, adr[19:1]);
            if (we) check({tag, "_wdat"}, sram_dat_o, exp_val);
            tick();
        end
        check({tag, "_ack"}, s_ack_o, 1'b1);
        check({tag, "_ctl_ack"}, ctl(), 5'b01111);
        check({tag, "_doe_ack"}, sram_dat_oe_o, we);
        if (we) check({tag, "_wdat_ack"}, sram_dat_o, exp_val);
        else    check({tag, "_rdat"}, s_dat_o, exp_val);
        s_cyc = 1'b0;
        tick();
        check({tag, "_ack_end"}, s_ack_o, 1'b0);
        check({tag, "_ctl_end"}, {ctl(), sram_dat_oe_o}, 6'b111110);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        int ack_c;
        int we_c;
        int exp_lat;
        logic [5:0] prev;
        logic any_ack;

        n_tests  = 0;
        n_fail   = 0;
        reset_i  = 1'b1;
        s_adr    = '0;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_siz    = 1'b0;
        s_signed = 1'b0;
        s_dat    = '0;
        rd_def   = 16'h0000;
        tick();
        tick();

        check("rst_ctl", {ctl(), sram_dat_oe_o}, 6'b111110);
        check("rst_ack", s_ack_o, 1'b0);
        check("rst_sdat", s_dat_o, 16'h0000);
        check("rst_adr", sram_adr_o, 19'h0);
        check("rst_wdat", sram_dat_o, 16'h0000);
        reset_i = 1'b0;
        tick();

        // Halfword read: 0x...21112 >> 1 = 0x10889
        rd_def = 16'hAA55;
        xfer("hw_rd", 64'h1111_2222_2222_1112, 1'b0, 1'b1, 16'h0, 5'b00100, 16'hAA55);
        rd_def = 16'hAA11;
        xfer("b_rd_odd", 64'h0000_0000_0000_1111, 1'b0, 1'b0, 16'h0, 5'b00101, 16'h00AA);
        xfer("b_rd_even", 64'h0000_0000_0000_1110, 1'b0, 1'b0, 16'h0, 5'b00110, 16'h0011);
        xfer("b_wr_odd", 64'h0000_0000_0000_1111, 1'b1, 1'b0, 16'h00DD, 5'b01001, 16'hDDDD);
        xfer("b_wr_even", 64'h0000_0000_0000_1110, 1'b1, 1'b0, 16'hAB77, 5'b01010, 16'h7777);
        xfer("hw_wr", 64'h0000_0000_0000_2000, 1'b1, 1'b1, 16'h1234, 5'b01000, 16'h1234);
        tick();

        // Two-beat word read with strobe held
        first  = -1;
        second = -1;
        s_adr  = 64'h1116;
        s_we   = 1'b0;
        s_siz  = 1'b1;
        s_cyc  = 1'b1;
        s_stb  = 1'b1;
        tick();
        for (int c = 1; c <= 25; c++) begin
            if (s_ack_o) begin
                if (first < 0) begin
                    first = c;
                    check("w2_dat0", s_dat_o, 16'hDEAD);
                    s_adr = 64'h1114;
                end else if (second < 0) begin
                    second = c;
                    check("w2_dat1", s_dat_o, 16'hBEEF);
                    s_cyc = 1'b0;
                    s_stb = 1'b0;
                end
            end
            tick();
        end
        check("w2_first", 64'(first), 64'(4));
        check("w2_gap", 64'(second - first), 64'(5));

        // Read immediately followed by a write: latency from ack to we_n falling
        ack_c = -1;
        we_c  = -1;
        prev  = '0;
        s_adr = 64'h40;
        s_we  = 1'b0;
        s_siz = 1'b1;
        s_cyc = 1'b1;
        s_stb = 1'b1;
        tick();
        for (int c = 1; c <= 20; c++) begin
            if (s_ack_o && ack_c < 0) begin
                ack_c = c;
                s_we  = 1'b1;
                s_adr = 64'h42;
                s_dat = 16'h5A5A;
            end else if (s_ack_o) begin
                s_cyc = 1'b0;
            end
            if (!sram_we_n_o && we_c < 0) begin
                we_c = c;
                check("ta_pre", prev, 6'b111110);
                s_stb = 1'b0;
            end
            prev = {ctl(), sram_dat_oe_o};
            tick();
        end
        s_cyc = 1'b0;
        s_stb = 1'b0;
`ifdef SRAM16_CTL_TURNAROUND_EN
        exp_lat = 3;
`else
        exp_lat = 2;
`endif
        check("ta_lat", 64'(we_c - ack_c), 64'(exp_lat));
        tick();

        // Abort: cyc dropped in the second ACCESS cycle
        rd_def = 16'h1234;
        s_adr  = 64'h1112;
        s_we   = 1'b0;
        s_siz  = 1'b1;
        s_cyc  = 1'b1;
        s_stb  = 1'b1;
        tick();
        s_stb = 1'b0;
        check("ab_c1", ctl(), 5'b00100);
        tick();
        s_cyc = 1'b0;
        check("ab_c2", ctl(), 5'b00100);
        tick();
        check("ab_c3", ctl(), 5'b00100);
        tick();
        check("ab_ack", s_ack_o, 1'b0);
        check("ab_ctl_ack", ctl(), 5'b01111);
        tick();
        check("ab_ack_end", s_ack_o, 1'b0);
        check("ab_ctl_end", ctl(), 5'b11111);

        // Reset asserted in ACCESS
        rd_def = 16'h4321;
        s_adr  = 64'h1112;
        s_cyc  = 1'b1;
        s_stb  = 1'b1;
        tick();
        s_stb = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        check("rs_ctl", {ctl(), sram_dat_oe_o}, 6'b111110);
        check("rs_sdat", s_dat_o, 16'h0000);
        check("rs_ack", s_ack_o, 1'b0);
        reset_i = 1'b0;
        any_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            any_ack = any_ack | s_ack_o;
        end
        s_cyc = 1'b0;
        check("rs_no_ack", any_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
